// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and read-source encoding for reg_file
// Optional flush support in reg_file is enabled with REGFILE_FLUSH_EN.
package reg_file_pkg;

  localparam int DataBus = 32;
  localparam int NameBus = 5;
  localparam int TagBus  = 5;
  localparam int RegNum  = 2 ** NameBus;

  typedef enum logic [1:0] {
    SrcZero,
    SrcStore,
    SrcBypass,
    SrcPending
  } readSrcT;

endpackage

// File: rtl/reg_file_rdport.sv
// rtl/reg_file_rdport.sv - one source-operand lookup with same-cycle commit bypass
// Instantiated per read port by reg_file.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DataBus,
  parameter int NAME_W = NameBus,
  parameter int TAG_W  = TagBus,
  parameter logic [TAG_W-1:0] TAG_FREE = '1
) (
  input  logic [NAME_W-1:0] readName,
  input  logic [TAG_W-1:0]  tagEntry,
  input  logic [DATA_W-1:0] dataEntry,
  input  logic              enCom,
  input  logic [TAG_W-1:0]  ComTag,
  input  logic [DATA_W-1:0] ComData,
  input  logic [NAME_W-1:0] ComName,
  output logic [DATA_W-1:0] readData,
  output logic [TAG_W-1:0]  readTag
);

  readSrcT src;

  // Bypass only when the committing entry is exactly the producer the table waits on.
  always_comb begin
    src = SrcPending;
    if (readName == '0)
      src = SrcZero;
    else if (tagEntry == TAG_FREE)
      src = SrcStore;
    else if (enCom && (ComName == readName) && (ComTag == tagEntry))
      src = SrcBypass;
  end

  always_comb begin
    readData = '0;
    readTag  = TAG_FREE;
    case (src)
      SrcZero:    begin readData = '0;        readTag = TAG_FREE; end
      SrcStore:   begin readData = dataEntry; readTag = TAG_FREE; end
      SrcBypass:  begin readData = ComData;   readTag = TAG_FREE; end
      SrcPending: begin readData = '0;        readTag = tagEntry; end
      default:    begin readData = '0;        readTag = TAG_FREE; end
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file and rename-tag table fed by ROB commits
// Define REGFILE_FLUSH_EN to add a flush input that frees every tag entry.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DataBus,
  parameter int NAME_W = NameBus,
  parameter int TAG_W  = TagBus,
  parameter logic [TAG_W-1:0] TAG_FREE = '1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef REGFILE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              enCom,
  input  logic [TAG_W-1:0]  ComTag,
  input  logic [DATA_W-1:0] ComData,
  input  logic [NAME_W-1:0] ComName,
  input  logic [NAME_W-1:0] ReadNameO,
  input  logic [NAME_W-1:0] ReadNameT,
  output logic [DATA_W-1:0] ReadDataO,
  output logic [TAG_W-1:0]  ReadTagO,
  output logic [DATA_W-1:0] ReadDataT,
  output logic [TAG_W-1:0]  ReadTagT,
  input  logic              renameEn,
  input  logic [NAME_W-1:0] renameName,
  input  logic [TAG_W-1:0]  renameTag
);

  localparam int NumRegs = 2 ** NAME_W;

  logic [DATA_W-1:0] dataArr [NumRegs];
  logic [TAG_W-1:0]  tagArr  [NumRegs];

  // Later non-blocking writes win: commit clear < rename < flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        dataArr[i] <= '0;
        tagArr[i]  <= TAG_FREE;
      end
    end else begin
      if (enCom && (ComName != '0)) begin
        dataArr[ComName] <= ComData;
        if (tagArr[ComName] == ComTag)
          tagArr[ComName] <= TAG_FREE;
      end
      if (renameEn && (renameName != '0))
        tagArr[renameName] <= renameTag;
`ifdef REGFILE_FLUSH_EN
      if (flush) begin
        for (int i = 0; i < NumRegs; i++)
          tagArr[i] <= TAG_FREE;
      end
`endif
    end
  end

  reg_file_rdport #(
    .DATA_W(DATA_W), .NAME_W(NAME_W), .TAG_W(TAG_W), .TAG_FREE(TAG_FREE)
  ) u_rdO (
    .readName (ReadNameO),
    .tagEntry (tagArr[ReadNameO]),
    .dataEntry(dataArr[ReadNameO]),
    .enCom    (enCom),
    .ComTag   (ComTag),
    .ComData  (ComData),
    .ComName  (ComName),
    .readData (ReadDataO),
    .readTag  (ReadTagO)
  );

  reg_file_rdport #(
    .DATA_W(DATA_W), .NAME_W(NAME_W), .TAG_W(TAG_W), .TAG_FREE(TAG_FREE)
  ) u_rdT (
    .readName (ReadNameT),
    .tagEntry (tagArr[ReadNameT]),
    .dataEntry(dataArr[ReadNameT]),
    .enCom    (enCom),
    .ComTag   (ComTag),
    .ComData  (ComData),
    .ComName  (ComName),
    .readData (ReadDataT),
    .readTag  (ReadTagT)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
// Flush steps run only when REGFILE_FLUSH_EN is defined.
module tb_reg_file;

  localparam logic [4:0] FREE = 5'h1F;

  logic        clk = 1'b0;
  logic        rst;
`ifdef REGFILE_FLUSH_EN
  logic        flush;
`endif
  logic        enCom;
  logic [4:0]  ComTag;
  logic [31:0] ComData;
  logic [4:0]  ComName;
  logic [4:0]  ReadNameO, ReadNameT;
  logic [31:0] ReadDataO, ReadDataT;
  logic [4:0]  ReadTagO, ReadTagT;
  logic        renameEn;
  logic [4:0]  renameName;
  logic [4:0]  renameTag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk       (clk),
    .rst       (rst),
`ifdef REGFILE_FLUSH_EN
    .flush     (flush),
`endif
    .enCom     (enCom),
    .ComTag    (ComTag),
    .ComData   (ComData),
    .ComName   (ComName),
    .ReadNameO (ReadNameO),
    .ReadNameT (ReadNameT),
    .ReadDataO (ReadDataO),
    .ReadTagO  (ReadTagO),
    .ReadDataT (ReadDataT),
    .ReadTagT  (ReadTagT),
    .renameEn  (renameEn),
    .renameName(renameName),
    .renameTag (renameTag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs settle mid-low-phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    enCom = 1'b0; ComTag = '0; ComData = '0; ComName = '0;
    renameEn = 1'b0; renameName = '0; renameTag = '0;
`ifdef REGFILE_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  initial begin
    idle();
    rst = 1'b0;
    ReadNameO = 5'd1;
    ReadNameT = 5'd31;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_r1_data", ReadDataO, 32'h0);
    chk("rst_r1_tag", {27'h0, ReadTagO}, {27'h0, FREE});
    chk("rst_r31_data", ReadDataT, 32'h0);
    chk("rst_r31_tag", {27'h0, ReadTagT}, {27'h0, FREE});

    // rename r5 -> tag 3; same-cycle read still sees old mapping
    renameEn = 1'b1; renameName = 5'd5; renameTag = 5'd3;
    ReadNameO = 5'd5; ReadNameT = 5'd5;
    #1;
    chk("r5_rename_invisible", {27'h0, ReadTagO}, {27'h0, FREE});
    tick();
    idle();
    #1;
    chk("r5_pending_tag", {27'h0, ReadTagO}, 32'd3);
    chk("r5_pending_data", ReadDataO, 32'h0);
    enCom = 1'b1; ComTag = 5'd3; ComData = 32'hDEADBEEF; ComName = 5'd5;
    #1;
    chk("r5_bypass_data_O", ReadDataO, 32'hDEADBEEF);
    chk("r5_bypass_tag_O", {27'h0, ReadTagO}, {27'h0, FREE});
    chk("r5_bypass_data_T", ReadDataT, 32'hDEADBEEF);
    chk("r5_bypass_tag_T", {27'h0, ReadTagT}, {27'h0, FREE});
    tick();
    idle();
    #1;
    chk("r5_stored_data", ReadDataO, 32'hDEADBEEF);
    chk("r5_stored_tag", {27'h0, ReadTagO}, {27'h0, FREE});

    // stale commit must not free a younger producer's tag
    renameEn = 1'b1; renameName = 5'd7; renameTag = 5'd2;
    tick();
    renameTag = 5'd9;
    tick();
    idle();
    enCom = 1'b1; ComTag = 5'd2; ComData = 32'h11; ComName = 5'd7;
    ReadNameO = 5'd7; ReadNameT = 5'd7;
    #1;
    chk("r7_stale_no_bypass_tag", {27'h0, ReadTagO}, 32'd9);
    chk("r7_stale_no_bypass_data", ReadDataO, 32'h0);
    tick();
    idle();
    #1;
    chk("r7_tag_kept", {27'h0, ReadTagT}, 32'd9);
    enCom = 1'b1; ComTag = 5'd9; ComData = 32'h33; ComName = 5'd7;
    tick();
    idle();
    #1;
    chk("r7_young_commit_data", ReadDataO, 32'h33);
    chk("r7_young_commit_tag", {27'h0, ReadTagO}, {27'h0, FREE});

    // same-cycle commit and rename of r8
    renameEn = 1'b1; renameName = 5'd8; renameTag = 5'd4;
    tick();
    idle();
    enCom = 1'b1; ComTag = 5'd4; ComData = 32'h22; ComName = 5'd8;
    renameEn = 1'b1; renameName = 5'd8; renameTag = 5'd6;
    ReadNameO = 5'd8; ReadNameT = 5'd8;
    #1;
    chk("r8_collide_data", ReadDataO, 32'h22);
    chk("r8_collide_tag", {27'h0, ReadTagO}, {27'h0, FREE});
    tick();
    idle();
    #1;
    chk("r8_rename_wins_tag", {27'h0, ReadTagO}, 32'd6);
    chk("r8_rename_wins_data", ReadDataT, 32'h0);

    // register 0 ignores everything
    renameEn = 1'b1; renameName = 5'd0; renameTag = 5'd1;
    enCom = 1'b1; ComTag = 5'd1; ComData = 32'h55; ComName = 5'd0;
    ReadNameO = 5'd0; ReadNameT = 5'd0;
    #1;
    chk("r0_same_data", ReadDataO, 32'h0);
    chk("r0_same_tag", {27'h0, ReadTagO}, {27'h0, FREE});
    tick();
    idle();
    #1;
    chk("r0_next_data", ReadDataT, 32'h0);
    chk("r0_next_tag", {27'h0, ReadTagT}, {27'h0, FREE});

`ifdef REGFILE_FLUSH_EN
    renameEn = 1'b1; renameName = 5'd3; renameTag = 5'd5;
    tick();
    renameName = 5'd4; renameTag = 5'd7;
    tick();
    idle();
    flush = 1'b1;
    renameEn = 1'b1; renameName = 5'd9; renameTag = 5'd8;
    ReadNameO = 5'd3; ReadNameT = 5'd4;
    #1;
    chk("flush_cycle_r3_tag", {27'h0, ReadTagO}, 32'd5);
    chk("flush_cycle_r4_tag", {27'h0, ReadTagT}, 32'd7);
    tick();
    idle();
    #1;
    chk("flush_r3_tag", {27'h0, ReadTagO}, {27'h0, FREE});
    chk("flush_r3_data", ReadDataO, 32'h0);
    chk("flush_r4_tag", {27'h0, ReadTagT}, {27'h0, FREE});
    ReadNameO = 5'd9; ReadNameT = 5'd5;
    #1;
    chk("flush_r9_tag", {27'h0, ReadTagO}, {27'h0, FREE});
    chk("flush_r5_data_kept", ReadDataT, 32'hDEADBEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
